sdram_device_responder: RTL and testbench

//  Synthesizable single-chip SDR SDRAM responder: the device end of the 16-bit SDRAM command bus driven by the system's SDRAM controller.

---
 rtl/sdram_device_responder.sv | 188 ++++++++++++++++++
 tb/tb_sdram_device_responder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_device_responder.sv
// SDR SDRAM device end: decodes controller commands, tracks open rows, serves masked reads/writes, flags protocol violations.
// Latency: READ data registered CL-1 edges after the command edge (sampled by the controller at CL); WRITE lands at the command edge.
// Backpressure: none; the controller owns all timing, violations are latched in err_flag/err_code rather than stalled.
module sdram_device_responder #(
    parameter int MEM_AW     = 12,
    parameter int COL_KEEP   = 5,
    parameter int TRCD       = 2,
    parameter int CL_DEFAULT = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err_flag,
    output logic [2:0]  err_code
);

    localparam int ROW_KEEP = MEM_AW - 2 - COL_KEEP;
    localparam int TW       = (TRCD > 1) ? $clog2(TRCD) : 1;

    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_AREF = 3'b001;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_ACT  = 3'b011;
    localparam logic [2:0] CMD_WR   = 3'b100;
    localparam logic [2:0] CMD_RD   = 3'b101;

    localparam logic [0:0] BANK_IDLE   = 1'b0;
    localparam logic [0:0] BANK_ACTIVE = 1'b1;

    logic [0:0]          bank_st  [4];
    logic [ROW_KEEP-1:0] bank_row [4];
    logic [TW-1:0]       trcd_cnt [4];
    logic [2:0]          cl;
    logic                mode_set;
    logic [15:0]         mem [2**MEM_AW];

    // Two-stage read pipeline: CL=3 reads enter stage 2, CL=2 reads enter stage 1.
    logic                s1_vld, s2_vld;
    logic [15:0]         s1_dat, s2_dat;

    logic                cmd_en;
    logic [2:0]          cmd;
    logic                is_act, is_rd, is_wr, is_pre, is_aref, is_mrs;
    logic                sel_active, sel_trcd_ok, any_active, cl_ok;
    logic                act_ok, rd_ok, wr_ok, mrs_ok;
    logic [2:0]          err_val;
    logic [MEM_AW-1:0]   mem_idx;
    logic [15:0]         mem_rd, rd_dat;
    logic                unused_ok;

    assign cmd_en  = sdram_cke & ~sdram_cs_n & ~reset_reset;
    assign cmd     = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_act  = cmd_en && (cmd == CMD_ACT);
    assign is_rd   = cmd_en && (cmd == CMD_RD);
    assign is_wr   = cmd_en && (cmd == CMD_WR);
    assign is_pre  = cmd_en && (cmd == CMD_PRE);
    assign is_aref = cmd_en && (cmd == CMD_AREF);
    assign is_mrs  = cmd_en && (cmd == CMD_MRS);

    assign sel_active  = (bank_st[sdram_ba] == BANK_ACTIVE);
    assign sel_trcd_ok = (trcd_cnt[sdram_ba] == '0);
    assign cl_ok       = (sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3);

    assign mem_idx = {sdram_ba, bank_row[sdram_ba], sdram_addr[COL_KEEP-1:0]};
    assign mem_rd  = mem[mem_idx];
    assign rd_dat  = {sdram_dqm[1] ? 8'h00 : mem_rd[15:8], sdram_dqm[0] ? 8'h00 : mem_rd[7:0]};

    // Only some address bits matter per command; the rest are intentionally ignored.
    assign unused_ok = ^sdram_addr;

    // Legality checks: pick the violation code (0 = none) and the enables for legal commands.
    always_comb begin
        any_active = 1'b0;
        for (int b = 0; b < 4; b++) begin
            any_active = any_active | (bank_st[b] == BANK_ACTIVE);
        end
        err_val = 3'd0;
        act_ok  = 1'b0;
        rd_ok   = 1'b0;
        wr_ok   = 1'b0;
        mrs_ok  = 1'b0;
        if (is_act) begin
            if (!mode_set)       err_val = 3'd4;
            else if (sel_active) err_val = 3'd2;
            else                 act_ok  = 1'b1;
        end
        if (is_rd || is_wr) begin
            if (!mode_set)         err_val = 3'd4;
            else if (!sel_active)  err_val = 3'd1;
            else if (!sel_trcd_ok) err_val = 3'd3;
            else begin
                rd_ok = is_rd;
                wr_ok = is_wr;
            end
        end
        if (is_aref && any_active) err_val = 3'd5;
        if (is_mrs) begin
            if (any_active)  err_val = 3'd5;
            else if (!cl_ok) err_val = 3'd6;
            else             mrs_ok  = 1'b1;
        end
    end

    // Per-bank open/close tracking with the ACT-to-access countdown.
    always_ff @(posedge clk_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (reset_reset) begin
                bank_st[b]  <= BANK_IDLE;
                bank_row[b] <= '0;
                trcd_cnt[b] <= '0;
            end else begin
                if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
                if (act_ok && (sdram_ba == 2'(b))) begin
                    bank_st[b]  <= BANK_ACTIVE;
                    bank_row[b] <= sdram_addr[ROW_KEEP-1:0];
                    trcd_cnt[b] <= TW'(TRCD - 1);
                end
                if (is_pre && (sdram_addr[10] || (sdram_ba == 2'(b)))) bank_st[b] <= BANK_IDLE;
            end
        end
    end

    // Mode register and first-violation latch.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cl       <= 3'(CL_DEFAULT);
            mode_set <= 1'b0;
            err_flag <= 1'b0;
            err_code <= 3'd0;
        end else begin
            if (mrs_ok) begin
                cl       <= sdram_addr[6:4];
                mode_set <= 1'b1;
            end
            if ((err_val != 3'd0) && !err_flag) begin
                err_flag <= 1'b1;
                err_code <= err_val;
            end
        end
    end

    // Backing store: byte-masked writes, never cleared by reset.
    always_ff @(posedge clk_clk) begin
        if (wr_ok) begin
            if (!sdram_dqm[1]) mem[mem_idx][15:8] <= dq_in[15:8];
            if (!sdram_dqm[0]) mem[mem_idx][7:0]  <= dq_in[7:0];
        end
    end

    // Read pipeline: data captured at the command edge, driven out CL-1 edges later for one cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1_vld <= 1'b0;
            s1_dat <= 16'h0;
            s2_vld <= 1'b0;
            s2_dat <= 16'h0;
            dq_oe  <= 1'b0;
            dq_out <= 16'h0;
        end else begin
            dq_oe  <= s1_vld;
            dq_out <= s1_vld ? s1_dat : 16'h0;
            s1_vld <= s2_vld;
            s1_dat <= s2_dat;
            s2_vld <= 1'b0;
            s2_dat <= 16'h0;
            if (rd_ok) begin
                if (cl == 3'd2) begin
                    s1_vld <= 1'b1;
                    s1_dat <= rd_dat;
                end else begin
                    s2_vld <= 1'b1;
                    s2_dat <= rd_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_device_responder.sv
// Bench for sdram_device_responder: directed table, corner sequences, then random traffic vs. a reference model.
// Every cycle is checked against the model; directed steps also carry hand-derived expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_sdram_device_responder;

    localparam int TRCD = 2;
    localparam logic [2:0] C_MRS  = 3'b000;
    localparam logic [2:0] C_AREF = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_WR   = 3'b100;
    localparam logic [2:0] C_RD   = 3'b101;
    localparam logic [2:0] C_NOP  = 3'b111;

    logic        clk_clk = 1'b0;
    logic        reset_reset, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba, sdram_dqm;
    logic [12:0] sdram_addr;
    logic [15:0] dq_in, dq_out;
    logic        dq_oe, err_flag;
    logic [2:0]  err_code;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_device_responder dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n),
        .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .err_flag(err_flag), .err_code(err_code)
    );

    // ---------------- reference model (cycle-numbered, event based) ----------------
    typedef struct {
        int          due;
        logic [15:0] dat;
        bit          known;
    } rd_t;

    bit          m_open [4];
    int          m_row  [4];
    int          m_act  [4];
    bit          m_mode;
    int          m_cl;
    int          m_err;
    int          cyc = 0;
    logic [15:0] m_mem [int];
    rd_t         m_q [$];
    bit          exp_oe, exp_known;
    logic [15:0] exp_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_err(input int code);
        if (m_err == 0) m_err = code;
    endtask

    task automatic model_step(input logic r, input logic ck, input logic cs, input logic [2:0] c,
                              input logic [1:0] b, input logic [12:0] a, input logic [1:0] m,
                              input logic [15:0] d);
        int  idx;
        bit  any_open;
        rd_t e;
        cyc++;
        exp_oe = 0; exp_out = 16'h0; exp_known = 1;
        if (r) begin
            for (int i = 0; i < 4; i++) m_open[i] = 0;
            m_mode = 0; m_cl = 3; m_err = 0;
            m_q.delete();
        end else begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].due == cyc) begin
                    exp_oe = 1; exp_out = m_q[i].dat; exp_known = m_q[i].known;
                    m_q.delete(i);
                    break;
                end
            end
            if (ck && !cs) begin
                any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
                idx = (int'(b) << 10) | ((m_row[b] & 31) << 5) | (int'(a) & 31);
                case (c)
                    C_ACT: begin
                        if (!m_mode) set_err(4);
                        else if (m_open[b]) set_err(2);
                        else begin
                            m_open[b] = 1; m_row[b] = int'(a); m_act[b] = cyc;
                        end
                    end
                    C_RD, C_WR: begin
                        if (!m_mode) set_err(4);
                        else if (!m_open[b]) set_err(1);
                        else if (cyc - m_act[b] < TRCD) set_err(3);
                        else if (c == C_RD) begin
                            e.due   = cyc + m_cl - 1;
                            e.known = m_mem.exists(idx);
                            e.dat   = e.known ? m_mem[idx] : 16'h0;
                            if (m[1]) e.dat[15:8] = 8'h00;
                            if (m[0]) e.dat[7:0]  = 8'h00;
                            m_q.push_back(e);
                        end else begin
                            if (m == 2'b00) m_mem[idx] = d;
                            else if (m_mem.exists(idx)) begin
                                if (!m[1]) m_mem[idx][15:8] = d[15:8];
                                if (!m[0]) m_mem[idx][7:0]  = d[7:0];
                            end
                        end
                    end
                    C_PRE: begin
                        for (int i = 0; i < 4; i++)
                            if (a[10] || (b == 2'(i))) m_open[i] = 0;
                    end
                    C_AREF: if (any_open) set_err(5);
                    C_MRS: begin
                        if (any_open) set_err(5);
                        else if ((a[6:4] != 3'd2) && (a[6:4] != 3'd3)) set_err(6);
                        else begin
                            m_cl = int'(a[6:4]); m_mode = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, check every output against the model.
    task automatic apply(input logic r, input logic ck, input logic cs, input logic [2:0] c,
                         input logic [1:0] b, input logic [12:0] a, input logic [1:0] m,
                         input logic [15:0] d);
        reset_reset = r; sdram_cke = ck; sdram_cs_n = cs;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba = b; sdram_addr = a; sdram_dqm = m; dq_in = d;
        @(posedge clk_clk);
        model_step(r, ck, cs, c, b, a, m, d);
        #1;
        chk($sformatf("cyc%0d_oe", cyc), 32'(dq_oe), 32'(exp_oe));
        if (exp_oe && exp_known) chk($sformatf("cyc%0d_dq_out", cyc), 32'(dq_out), 32'(exp_out));
        chk($sformatf("cyc%0d_err_flag", cyc), 32'(err_flag), 32'(m_err != 0));
        chk($sformatf("cyc%0d_err_code", cyc), 32'(err_code), 32'(m_err));
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        apply(1'b0, 1'b1, 1'b0, c, b, a, 2'b00, 16'h0);
    endtask

    task automatic rst();
        apply(1'b1, 1'b1, 1'b0, C_NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst;
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        exp_oe;
        logic [15:0] exp_out;
        logic [2:0]  exp_err;
    } vec_t;

    localparam int NV = 36;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [1:0] b,
                                input logic [12:0] a, input logic [1:0] m, input logic [15:0] d,
                                input logic eo, input logic [15:0] ed, input logic [2:0] ee);
        vec_t v;
        v.rst = r; v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.dq = d;
        v.exp_oe = eo; v.exp_out = ed; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        reset_reset = 1'b1; sdram_cke = 1'b1; sdram_cs_n = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
        sdram_ba = 2'd0; sdram_addr = 13'd0; sdram_dqm = 2'b00; dq_in = 16'h0;

        // CL=3 write/read, then CL=2 masked write/read, back-to-back reads, closed-bank read.
        tbl[0]  = mk(1, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[1]  = mk(0, C_MRS, 0, 13'h030, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[2]  = mk(0, C_ACT, 0, 13'h005, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[3]  = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[4]  = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[5]  = mk(0, C_WR,  0, 13'h007, 2'b00, 16'hBEEF, 0, 16'h0000, 0);
        tbl[6]  = mk(0, C_RD,  0, 13'h007, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[7]  = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[8]  = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 1, 16'hBEEF, 0);
        tbl[9]  = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[10] = mk(0, C_PRE, 0, 13'h400, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[11] = mk(0, C_MRS, 0, 13'h020, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[12] = mk(0, C_ACT, 0, 13'h005, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[13] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[14] = mk(0, C_WR,  0, 13'h009, 2'b00, 16'h1234, 0, 16'h0000, 0);
        tbl[15] = mk(0, C_WR,  0, 13'h009, 2'b10, 16'hABCD, 0, 16'h0000, 0);
        tbl[16] = mk(0, C_RD,  0, 13'h009, 2'b01, 16'h0000, 0, 16'h0000, 0);
        tbl[17] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 1, 16'h1200, 0);
        tbl[18] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[19] = mk(0, C_ACT, 1, 13'h001, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[20] = mk(0, C_ACT, 2, 13'h002, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[21] = mk(0, C_ACT, 3, 13'h003, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[22] = mk(0, C_WR,  1, 13'h001, 2'b00, 16'h1111, 0, 16'h0000, 0);
        tbl[23] = mk(0, C_WR,  2, 13'h002, 2'b00, 16'h2222, 0, 16'h0000, 0);
        tbl[24] = mk(0, C_WR,  3, 13'h003, 2'b00, 16'h3333, 0, 16'h0000, 0);
        tbl[25] = mk(0, C_RD,  0, 13'h007, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[26] = mk(0, C_RD,  1, 13'h001, 2'b00, 16'h0000, 1, 16'hBEEF, 0);
        tbl[27] = mk(0, C_RD,  2, 13'h002, 2'b00, 16'h0000, 1, 16'h1111, 0);
        tbl[28] = mk(0, C_RD,  3, 13'h003, 2'b00, 16'h0000, 1, 16'h2222, 0);
        tbl[29] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 1, 16'h3333, 0);
        tbl[30] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[31] = mk(0, C_PRE, 2, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 0);
        tbl[32] = mk(0, C_RD,  2, 13'h002, 2'b00, 16'h0000, 0, 16'h0000, 1);
        tbl[33] = mk(0, C_NOP, 0, 13'h000, 2'b00, 16'h0000, 0, 16'h0000, 1);
        tbl[34] = mk(0, C_ACT, 1, 13'h001, 2'b00, 16'h0000, 0, 16'h0000, 1);
        tbl[35] = mk(0, C_ACT, 1, 13'h001, 2'b00, 16'h0000, 0, 16'h0000, 1);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].rst, 1'b1, 1'b0, tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].dqm, tbl[i].dq);
            chk($sformatf("tbl%0d_oe", i), 32'(dq_oe), 32'(tbl[i].exp_oe));
            if (tbl[i].exp_oe) chk($sformatf("tbl%0d_dq_out", i), 32'(dq_out), 32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_err_code", i), 32'(err_code), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_err_flag", i), 32'(err_flag), 32'(tbl[i].exp_err != 3'd0));
        end

        // tRCD violation: READ one cycle after ACT gives code 3 and no data.
        rst(); cmd(C_MRS, 2'd0, 13'h030); cmd(C_ACT, 2'd0, 13'h005); cmd(C_RD, 2'd0, 13'h007);
        chk("trcd_err_code", 32'(err_code), 32'd3);
        for (int i = 0; i < 4; i++) begin
            cmd(C_NOP, 2'd0, 13'd0);
            chk($sformatf("trcd_no_data%0d", i), 32'(dq_oe), 32'd0);
        end

        // ACT before any MRS.
        rst(); cmd(C_ACT, 2'd0, 13'h005);
        chk("act_before_mrs", 32'(err_code), 32'd4);

        // MRS with an unsupported CL.
        rst(); cmd(C_MRS, 2'd0, 13'h010);
        chk("mrs_bad_cl", 32'(err_code), 32'd6);

        // MRS while a bank is open.
        rst(); cmd(C_MRS, 2'd0, 13'h030); cmd(C_ACT, 2'd1, 13'h001); cmd(C_NOP, 2'd0, 13'd0);
        cmd(C_MRS, 2'd0, 13'h020);
        chk("mrs_bank_open", 32'(err_code), 32'd5);

        // Reset one edge after a READ drops it; banks come back idle.
        rst(); cmd(C_MRS, 2'd0, 13'h030); cmd(C_ACT, 2'd0, 13'h005);
        cmd(C_NOP, 2'd0, 13'd0); cmd(C_NOP, 2'd0, 13'd0); cmd(C_RD, 2'd0, 13'h007);
        rst();
        chk("rst_drop_oe0", 32'(dq_oe), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cmd(C_NOP, 2'd0, 13'd0);
            chk($sformatf("rst_drop_oe%0d", i + 1), 32'(dq_oe), 32'd0);
        end
        cmd(C_AREF, 2'd0, 13'd0);
        chk("rst_banks_idle", 32'(err_flag), 32'd0);

        // Memory survives reset: the CL=3 word is still there.
        cmd(C_MRS, 2'd0, 13'h030); cmd(C_ACT, 2'd0, 13'h005);
        cmd(C_NOP, 2'd0, 13'd0); cmd(C_NOP, 2'd0, 13'd0); cmd(C_RD, 2'd0, 13'h007);
        cmd(C_NOP, 2'd0, 13'd0); cmd(C_NOP, 2'd0, 13'd0);
        chk("mem_kept_oe", 32'(dq_oe), 32'd1);
        chk("mem_kept_dat", 32'(dq_out), 32'h0000BEEF);

        // PRE with A10 closes every bank; AREF and a fresh ACT are then legal.
        cmd(C_ACT, 2'd3, 13'h003); cmd(C_NOP, 2'd0, 13'd0);
        cmd(C_PRE, 2'd1, 13'h400); cmd(C_AREF, 2'd0, 13'd0);
        chk("pre_all_aref", 32'(err_flag), 32'd0);
        cmd(C_ACT, 2'd0, 13'h005); cmd(C_ACT, 2'd3, 13'h003);
        chk("pre_all_reopen", 32'(err_code), 32'd0);

        // A READ with cke low is ignored.
        cmd(C_NOP, 2'd0, 13'd0);
        apply(1'b0, 1'b0, 1'b0, C_RD, 2'd0, 13'h007, 2'b00, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cmd(C_NOP, 2'd0, 13'd0);
            chk($sformatf("cke_low_oe%0d", i), 32'(dq_oe), 32'd0);
        end

        // Random traffic checked cycle by cycle against the model.
        rst(); cmd(C_MRS, 2'd0, 13'h030);
        for (int n = 0; n < 800; n++) begin
            int          p;
            logic [2:0]  c;
            logic [1:0]  b, m;
            logic [12:0] a;
            logic        ck, cs;
            p  = int'($urandom_range(99));
            b  = 2'($urandom_range(3));
            ck = ($urandom_range(15) != 0);
            cs = ($urandom_range(15) == 0);
            a  = 13'($urandom_range(3));
            m  = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(3));
            if (p < 20)      c = C_NOP;
            else if (p < 40) c = C_ACT;
            else if (p < 62) c = C_RD;
            else if (p < 84) c = C_WR;
            else if (p < 94) begin
                c = C_PRE;
                if ($urandom_range(3) == 0) a = 13'h400;
            end
            else if (p < 97) c = C_AREF;
            else begin
                c = C_MRS;
                a = 13'($urandom_range(3, 1) << 4);
            end
            if ($urandom_range(149) == 0) begin
                rst();
                cmd(C_MRS, 2'd0, 13'($urandom_range(3, 2) << 4));
            end
            apply(1'b0, ck, cs, c, b, a, m, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
